// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg
//  Shared definitions for the LED pattern engine: the pattern mode encoding
//  used on the config port and inside the top-level mode register.
package led_pattern_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
//  Time base for the pattern engine. A prescaler divides the clock down to
//  one tick every PRESCALE cycles; a step counter then produces one step
//  every 'period' ticks (period 0 behaves as 1).
// Ports
//  clk      in   system clock
//  rst_n    in   asynchronous active-low reset
//  period   in   ticks per step
//  restart  in   synchronous clear of both counters
//  step     out  single-cycle step strobe
module led_tick_gen #(
  parameter int PRESCALE = 27000,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                step
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PERIOD_W-1:0] step_cnt_q, step_cnt_d;
  logic [PERIOD_W-1:0] last_step;
  logic                tick;

  // Strobes are kept apart from the counter update so that restart, which
  // the parent derives from step, never forms a loop through this block.
  always_comb begin
    last_step = (period == '0) ? '0 : period - PERIOD_W'(1);
    tick      = (pre_cnt_q == PRE_W'(PRESCALE - 1));
    step      = tick && (step_cnt_q == last_step);
  end

  always_comb begin
    pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
    step_cnt_d = step_cnt_q;
    if (tick) begin
      step_cnt_d = step ? '0 : step_cnt_q + PERIOD_W'(1);
    end
    if (restart) begin
      pre_cnt_d  = '0;
      step_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q  <= '0;
      step_cnt_q <= '0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//  LED pattern engine driving NUM_LEDS pins in BLINK, CHASE, BOUNCE or
//  BREATHE (PWM) mode at a programmable step rate. A new mode/period is
//  taken over a valid/ready port, held pending, and applied at the next step.
// Ports
//  clk         in   system clock
//  rst_n       in   asynchronous active-low reset
//  cfg_valid   in   config request
//  cfg_ready   out  high while no config is pending
//  cfg_mode    in   requested mode (mode_e encoding)
//  cfg_period  in   requested ticks per step (0 behaves as 1)
//  led         out  LED pins, inverted when ACTIVE_LOW
//  beat        out  one-cycle pulse per pattern step
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int TICK_HZ    = 1000,
  parameter int NUM_LEDS   = 6,
  parameter int PERIOD_W   = 16,
  parameter int PWM_BITS   = 8,
  parameter int DEF_PERIOD = 500,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [NUM_LEDS-1:0] led,
  output logic                beat
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [NUM_LEDS-1:0] LED_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  mode_e                mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic [PERIOD_W-1:0]  period_q, period_d, pend_period_q, pend_period_d;
  logic                 pending_q, pending_d;
  logic                 phase_q, phase_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 pos_up_q, pos_up_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic                 duty_up_q, duty_up_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic                 beat_q, beat_d;
  logic [NUM_LEDS-1:0]  pattern;
  logic                 step, accept, apply;

  // A pending config can only apply on a step after the cycle it was
  // accepted in, so accept and apply are never true together.
  assign cfg_ready = ~pending_q;
  assign accept    = cfg_valid & cfg_ready;
  assign apply     = step & pending_q;

  led_tick_gen #(
    .PRESCALE (PRESCALE),
    .PERIOD_W (PERIOD_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .period  (period_q),
    .restart (apply),
    .step    (step)
  );

  // Config handshake: latch on accept, load into the live registers at the
  // next step edge.
  always_comb begin
    mode_d        = mode_q;
    period_d      = period_q;
    pending_d     = pending_q;
    pend_mode_d   = pend_mode_q;
    pend_period_d = pend_period_q;
    if (accept) begin
      pend_mode_d   = mode_e'(cfg_mode);
      pend_period_d = cfg_period;
      pending_d     = 1'b1;
    end
    if (apply) begin
      mode_d    = pend_mode_q;
      period_d  = pend_period_q;
      pending_d = 1'b0;
    end
  end

  // Pattern state: a freshly applied config restarts from the mode's start
  // state instead of advancing on that step.
  always_comb begin
    phase_d   = phase_q;
    pos_d     = pos_q;
    pos_up_d  = pos_up_q;
    duty_d    = duty_q;
    duty_up_d = duty_up_q;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    if (apply) begin
      phase_d   = 1'b0;
      pos_d     = '0;
      pos_up_d  = 1'b1;
      duty_d    = '0;
      duty_up_d = 1'b1;
    end else if (step) begin
      case (mode_q)
        MODE_BLINK: phase_d = ~phase_q;
        MODE_CHASE: pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
        MODE_BOUNCE: begin
          // Turn around at either end so each endpoint is lit once per pass.
          if (NUM_LEDS > 1) begin
            if (pos_up_q) begin
              if (pos_q == POS_MAX) begin
                pos_d    = pos_q - POS_W'(1);
                pos_up_d = 1'b0;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d    = pos_q + POS_W'(1);
                pos_up_d = 1'b1;
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
          end
        end
        MODE_BREATHE: begin
          if (duty_up_q) begin
            if (duty_q == DUTY_MAX) begin
              duty_d    = duty_q - PWM_BITS'(1);
              duty_up_d = 1'b0;
            end else begin
              duty_d = duty_q + PWM_BITS'(1);
            end
          end else begin
            if (duty_q == '0) begin
              duty_d    = duty_q + PWM_BITS'(1);
              duty_up_d = 1'b1;
            end else begin
              duty_d = duty_q - PWM_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output pattern is built from the next state so the pins change on the
  // same edge that raises beat.
  always_comb begin
    pattern = '0;
    case (mode_d)
      MODE_BLINK:   pattern = {NUM_LEDS{phase_d}};
      MODE_BREATHE: pattern = {NUM_LEDS{pwm_cnt_q < duty_d}};
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          pattern[i] = (pos_d == POS_W'(i));
        end
      end
    endcase
    led_d  = (ACTIVE_LOW != 0) ? ~pattern : pattern;
    beat_d = step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= MODE_BLINK;
      period_q      <= PERIOD_W'(DEF_PERIOD);
      pending_q     <= 1'b0;
      pend_mode_q   <= MODE_BLINK;
      pend_period_q <= '0;
      phase_q       <= 1'b0;
      pos_q         <= '0;
      pos_up_q      <= 1'b1;
      duty_q        <= '0;
      duty_up_q     <= 1'b1;
      pwm_cnt_q     <= '0;
      led_q         <= LED_OFF;
      beat_q        <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      period_q      <= period_d;
      pending_q     <= pending_d;
      pend_mode_q   <= pend_mode_d;
      pend_period_q <= pend_period_d;
      phase_q       <= phase_d;
      pos_q         <= pos_d;
      pos_up_q      <= pos_up_d;
      duty_q        <= duty_d;
      duty_up_q     <= duty_up_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_q         <= led_d;
      beat_q        <= beat_d;
    end
  end

  assign led  = led_q;
  assign beat = beat_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
//  Self-checking bench for led_pattern_gen with a 10-cycle tick, 4 active-low
//  LEDs and 3-bit breathe resolution. Expected LED words and duty counts are
//  queued when a scenario is set up and popped as beats arrive.
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_period = 16'd0;
  logic [3:0]  led;
  logic        beat;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  int         duty_q[$];

  led_pattern_gen #(
    .CLK_HZ     (100),
    .TICK_HZ    (10),
    .NUM_LEDS   (4),
    .PERIOD_W   (16),
    .PWM_BITS   (3),
    .DEF_PERIOD (2),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .led        (led),
    .beat       (beat)
  );

  always #5 clk = ~clk;

  // Advance negedge by negedge until beat is seen, bounded.
  task automatic wait_beat(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (!ok && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (beat === 1'b1) ok = 1'b1;
    end
  endtask

  // Hold a request until the handshake completes; returns at the negedge
  // after the accepting posedge.
  task automatic send_cfg(input logic [1:0] m, input logic [15:0] p, output bit ok);
    cfg_mode = m;
    cfg_period = p;
    cfg_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (cfg_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (led !== 4'b1111) begin failures++; $display("[TB] FAIL reset_led got %b expected 1111", led); end
    checks++; if (beat !== 1'b0) begin failures++; $display("[TB] FAIL reset_beat got %b expected 0", beat); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got %b expected 1", cfg_ready); end
    rst_n = 1'b1;
  endtask

  // Beats come every 20 clk (period 2 x prescale 10); leds alternate on/off.
  task automatic test_blink();
    int c; bit ok; logic [3:0] e;
    for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? 4'b0000 : 4'b1111);
    for (int k = 0; k < 4; k++) begin
      wait_beat(c, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL blink_timeout beat %0d not seen", k); end
      else begin
        checks++; if (c !== 20) begin failures++; $display("[TB] FAIL blink_interval got %0d expected 20", c); end
        checks++; if (led !== e) begin failures++; $display("[TB] FAIL blink_led got %b expected %b", led, e); end
      end
    end
  endtask

  task automatic test_chase();
    int c; bit ok; logic [3:0] e;
    send_cfg(2'd1, 16'd1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL chase_accept not accepted"); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("[TB] FAIL chase_ready_drop got %b expected 0", cfg_ready); end
    exp_q.push_back(4'b1110); exp_q.push_back(4'b1101); exp_q.push_back(4'b1011);
    exp_q.push_back(4'b0111); exp_q.push_back(4'b1110);
    for (int k = 0; k < 5; k++) begin
      wait_beat(c, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL chase_timeout beat %0d not seen", k); end
      else begin
        if (k == 0) begin
          checks++; if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL chase_ready_back got %b expected 1", cfg_ready); end
        end else begin
          checks++; if (c !== 10) begin failures++; $display("[TB] FAIL chase_interval got %0d expected 10", c); end
        end
        checks++; if (led !== e) begin failures++; $display("[TB] FAIL chase_led got %b expected %b", led, e); end
      end
    end
  endtask

  task automatic test_bounce();
    int c; bit ok; logic [3:0] e; logic [3:0] onehot;
    int pos_seq[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    send_cfg(2'd2, 16'd1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL bounce_accept not accepted"); end
    for (int k = 0; k < 8; k++) begin
      onehot = 4'b0001 << pos_seq[k];
      exp_q.push_back(~onehot);
    end
    for (int k = 0; k < 8; k++) begin
      wait_beat(c, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL bounce_timeout beat %0d not seen", k); end
      else begin
        checks++; if (led !== e) begin failures++; $display("[TB] FAIL bounce_led step %0d got %b expected %b", k, led, e); end
      end
    end
  endtask

  // Over any 8 consecutive clocks the free-running 3-bit PWM counter takes
  // every value once, so the lit count must equal the duty.
  task automatic test_breathe();
    int c; bit ok; int e; int lit; int bad;
    send_cfg(2'd3, 16'd1, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL breathe_accept not accepted"); end
    for (int d = 0; d <= 7; d++) duty_q.push_back(d);
    for (int d = 6; d >= 0; d--) duty_q.push_back(d);
    duty_q.push_back(1);
    for (int k = 0; k < 16; k++) begin
      wait_beat(c, ok);
      e = duty_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL breathe_timeout beat %0d not seen", k); end
      else begin
        lit = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
          if (i != 0) @(negedge clk);
          if (led === 4'b0000) lit++;
          else if (led !== 4'b1111) bad++;
        end
        checks++; if (lit !== e) begin failures++; $display("[TB] FAIL breathe_duty step %0d got %0d lit expected %0d", k, lit, e); end
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL breathe_uniform got %0d mixed samples expected 0", bad); end
      end
    end
  endtask

  task automatic test_period_zero();
    int c; bit ok; logic [3:0] e;
    send_cfg(2'd1, 16'd0, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL pzero_accept not accepted"); end
    exp_q.push_back(4'b1110); exp_q.push_back(4'b1101); exp_q.push_back(4'b1011);
    for (int k = 0; k < 3; k++) begin
      wait_beat(c, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("[TB] FAIL pzero_timeout beat %0d not seen", k); end
      else begin
        if (k != 0) begin
          checks++; if (c !== 10) begin failures++; $display("[TB] FAIL pzero_interval got %0d expected 10", c); end
        end
        checks++; if (led !== e) begin failures++; $display("[TB] FAIL pzero_led got %b expected %b", led, e); end
      end
    end
  endtask

  // First request BLINK/3, second BOUNCE/1 held on the bus while stalled.
  task automatic test_back_to_back();
    int c; bit ok; logic [3:0] e;
    send_cfg(2'd0, 16'd3, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL b2b_accept_a not accepted"); end
    cfg_mode = 2'd2; cfg_period = 16'd1; cfg_valid = 1'b1;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stall got ready %b expected 0", cfg_ready); end
    exp_q.push_back(4'b1111); exp_q.push_back(4'b1110); exp_q.push_back(4'b1101);
    wait_beat(c, ok);
    e = exp_q.pop_front();
    checks++; if (!ok) begin failures++; $display("[TB] FAIL b2b_timeout_a apply not seen"); end
    checks++; if (led !== e) begin failures++; $display("[TB] FAIL b2b_led_a got %b expected %b", led, e); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_a got %b expected 1", cfg_ready); end
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_accept_b got ready %b expected 0", cfg_ready); end
    wait_beat(c, ok);
    e = exp_q.pop_front();
    checks++; if (!ok) begin failures++; $display("[TB] FAIL b2b_timeout_b apply not seen"); end
    checks++; if (c + 1 !== 30) begin failures++; $display("[TB] FAIL b2b_interval_a got %0d expected 30", c + 1); end
    checks++; if (led !== e) begin failures++; $display("[TB] FAIL b2b_led_b got %b expected %b", led, e); end
    wait_beat(c, ok);
    e = exp_q.pop_front();
    checks++; if (c !== 10 || !ok) begin failures++; $display("[TB] FAIL b2b_interval_b got %0d expected 10", c); end
    checks++; if (led !== e) begin failures++; $display("[TB] FAIL b2b_led_b2 got %b expected %b", led, e); end
  endtask

  task automatic test_reset_mid();
    int c; bit ok; logic [3:0] e;
    send_cfg(2'd1, 16'd1, ok);
    wait_beat(c, ok);
    wait_beat(c, ok);
    checks++; if (led !== 4'b1101) begin failures++; $display("[TB] FAIL rmid_chase got %b expected 1101", led); end
    send_cfg(2'd3, 16'd5, ok);
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmid_pending got ready %b expected 0", cfg_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led !== 4'b1111) begin failures++; $display("[TB] FAIL rmid_led got %b expected 1111", led); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_ready got %b expected 1", cfg_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'b0000); exp_q.push_back(4'b1111);
    for (int k = 0; k < 2; k++) begin
      wait_beat(c, ok);
      e = exp_q.pop_front();
      checks++; if (c !== 20 || !ok) begin failures++; $display("[TB] FAIL rmid_interval got %0d expected 20", c); end
      checks++; if (led !== e) begin failures++; $display("[TB] FAIL rmid_led_after got %b expected %b", led, e); end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_chase();
    test_bounce();
    test_breathe();
    test_period_zero();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
